lbus_arbiter_ctrl: RTL and testbench
====================================

Name: lbus_arbiter_ctrl

Overview:
- Transaction controller and arbiter for the SAKURA-G local bus (lbus_di_a / lbus_do / lbus_wrn / lbus_rdn / lbus_rstn) toward the crypto FPGA.
- Shares the bus between two requesters:
  - port 0: host register path, driven by the USB register interface;
  - port 1: auto-run engine that loads key/plaintext and reads ciphertext.
- Sequences each single-word read or write as a fixed-phase bus cycle and issues timed remote resets.
- Sits between the register blocks and the lbus pins, in the usb_clk domain.

Parameters:
- RD_LAT, 2: cycles rdn is held low after the address phase before lbus_do is sampled; minimum 1.
- GAP_CYC, 1: idle cycles, with wrn=rdn=1, after each transaction; minimum 1.
- RST_CYC, 8: cycles lbus_rstn is held low per reset request; minimum 1.

Ports:
- clk, in, 1: usb_clk domain clock.
- reset_i, in, 1: synchronous, active-high reset.
- req0, in, 1: requester 0 transaction request; held until done0.
- we0, in, 1: requester 0 direction; 1 = write, 0 = read.
- addr0, in, 16: requester 0 word address.
- wdata0, in, 16: requester 0 write data.
- done0, out, 1: one-cycle completion pulse to requester 0.
- rdata0, out, 16: requester 0 read data; valid when done0 is high.
- req1, we1, addr1, wdata1, done1, rdata1: same as port 0, for requester 1.
- rst_req, in, 1: pulse requesting a remote reset.
- busy, out, 1: high whenever the FSM is not in IDLE.
- lbus_di_a, out, 16: address/data to the crypto FPGA.
- lbus_do, in, 16: read data from the crypto FPGA.
- lbus_wrn, out, 1: active-low write strobe.
- lbus_rdn, out, 1: active-low read strobe.
- lbus_rstn, out, 1: active-low remote reset.

Behaviour:
- All outputs are registered. Reset values: lbus_di_a=0, lbus_wrn=1, lbus_rdn=1, lbus_rstn=1, done0=done1=0, rdata0=rdata1=0, busy=0, FSM=IDLE, rr_last=1 (so requester 0 wins first).
- FSM states: IDLE, WADDR, WDATA, RADDR, RWAIT, RCAP, GAP, RST.
- IDLE priority order:
  1. rst_req pending → RST. rst_req is latched into a sticky flag, so a pulse that arrives while busy is not lost.
  2. Otherwise arbitrate among eligible requesters. A requester is eligible if its req=1 and its done is not high this cycle.
  3. If both are eligible, round-robin: grant the one not equal to rr_last.
  4. On grant, latch the winner's we/addr/wdata and update rr_last.
- Write path:
  - WADDR: 1 cycle, lbus_di_a=addr, wrn=0.
  - WDATA: 1 cycle, lbus_di_a=wdata, wrn=0.
  - Then GAP.
- Read path:
  - RADDR: 1 cycle, lbus_di_a=addr, rdn=0.
  - RWAIT: RD_LAT cycles, rdn=0, lbus_di_a held.
  - RCAP: rdn=1; lbus_do is captured into rdata of the granted port.
  - Then GAP.
- GAP: GAP_CYC cycles with wrn=rdn=1 and lbus_di_a held. On exit, done of the granted port pulses for 1 cycle (the first IDLE cycle).
- Latency from grant cycle t (the IDLE cycle in which the grant is made) to done:
  - write: t + 3 + GAP_CYC;
  - read: t + 3 + RD_LAT + GAP_CYC.
- rdata of the non-granted port is unchanged.
- RST: lbus_rstn=0 for RST_CYC cycles, then lbus_rstn=1 and return to IDLE; clears the sticky flag. No done pulse. Requests wait.
- wrn and rdn are never low in the same cycle. lbus_rstn is never low while wrn or rdn is low.
- Requester contract: keep req high and operands stable until done; drop req in the done cycle or later. A req that is still high the cycle after done starts a new transaction.
- A requester that drops req mid-transaction does not abort it; done still pulses.
- reset_i mid-transaction: next cycle all outputs return to reset values and no done is issued.
- Counter widths: sized by $clog2 of max(RD_LAT, GAP_CYC, RST_CYC) + 1; wrap is never reached.

Decomposition:
- Shared package lbus_pkg:
  - FSM state enum;
  - LBUS_AW=16, LBUS_DW=16;
  - constants WRN_IDLE=1, RDN_IDLE=1.
- One natural sub-module, lbus_rr_arb2: 2-input round-robin arbiter with done-masking, combinational grant plus rr_last register.
- The FSM and phase counter stay in the top module.

Test Plan:
- Single write: req0, we0=1, addr0=0x0002, wdata0=0x1234. Expected: lbus_di_a=0x0002 with wrn=0 for one cycle, then 0x1234 with wrn=0 for one cycle, 1 GAP cycle, done0 at t+4; done1 never pulses.
- Single read: req1, we1=0, addr1=0x0180, lbus_do=0xBEEF, RD_LAT=2. Expected: rdn=0 for 3 cycles, rdata1=0xBEEF when done1 pulses at t+6; rdata0 unchanged.
- Contention: req0 and req1 held high continuously for 4 transactions. Expected grant order 0,1,0,1; no back-to-back grant to the same port; wrn/rdn high between transactions.
- Reset request: rst_req pulses during an active write. Expected: the write completes with done0, then lbus_rstn=0 for exactly 8 cycles; a req1 raised meanwhile is granted only after lbus_rstn returns to 1.
- reset_i asserted in RWAIT. Expected: next cycle rdn=1, busy=0, no done pulse, rr_last=1. After reset, a req1-only read completes normally.
- Assertions, running throughout all tests:
  - never (wrn=0 and rdn=0);
  - never (lbus_rstn=0 and (wrn=0 or rdn=0));
  - done0 and done1 are one-hot-or-zero.

Source files
------------

// File: rtl/lbus_pkg.sv
// Shared definitions for the SAKURA-G local-bus controller: bus widths,
// strobe idle levels, FSM state encoding and a counter-sizing helper.
package lbus_pkg;

  localparam int LBUS_AW = 16;
  localparam int LBUS_DW = 16;

  localparam logic WRN_IDLE = 1'b1;
  localparam logic RDN_IDLE = 1'b1;

  typedef logic [2:0] lbus_state_t;

  localparam lbus_state_t S_IDLE  = 3'd0;
  localparam lbus_state_t S_WADDR = 3'd1;
  localparam lbus_state_t S_WDATA = 3'd2;
  localparam lbus_state_t S_RADDR = 3'd3;
  localparam lbus_state_t S_RWAIT = 3'd4;
  localparam lbus_state_t S_RCAP  = 3'd5;
  localparam lbus_state_t S_GAP   = 3'd6;
  localparam lbus_state_t S_RST   = 3'd7;

  function automatic int cnt_max(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lbus_rr_arb2.sv
// Two-requester round-robin arbiter. A requester whose done is high this
// cycle is masked so it cannot be re-granted in its own completion cycle.
module lbus_rr_arb2 (
  input  logic       clk,
  input  logic       reset_i,
  input  logic [1:0] req,
  input  logic [1:0] done,
  input  logic       grant_en,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic [1:0] elig;
  logic       rr_last;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    elig      = req & ~done;
    gnt_valid = |elig;
    gnt_idx   = elig[1];
    if (&elig) gnt_idx = ~rr_last;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset_i)                     rr_last <= 1'b1;
    else if (grant_en && gnt_valid)  rr_last <= gnt_idx;
  end

endmodule

// File: rtl/lbus_arbiter_ctrl.sv
// Local-bus transaction controller: arbitrates two requesters and sequences
// fixed-phase single-word writes, reads and timed remote resets.
module lbus_arbiter_ctrl
  import lbus_pkg::*;
#(
  parameter int RD_LAT  = 2,
  parameter int GAP_CYC = 1,
  parameter int RST_CYC = 8
) (
  input  logic               clk,
  input  logic               reset_i,
  input  logic               req0,
  input  logic               we0,
  input  logic [LBUS_AW-1:0] addr0,
  input  logic [LBUS_DW-1:0] wdata0,
  output logic               done0,
  output logic [LBUS_DW-1:0] rdata0,
  input  logic               req1,
  input  logic               we1,
  input  logic [LBUS_AW-1:0] addr1,
  input  logic [LBUS_DW-1:0] wdata1,
  output logic               done1,
  output logic [LBUS_DW-1:0] rdata1,
  input  logic               rst_req,
  output logic               busy,
  output logic [LBUS_DW-1:0] lbus_di_a,
  input  logic [LBUS_DW-1:0] lbus_do,
  output logic               lbus_wrn,
  output logic               lbus_rdn,
  output logic               lbus_rstn
);

  localparam int CNT_W = $clog2(cnt_max(RD_LAT, GAP_CYC, RST_CYC) + 1);

  lbus_state_t        state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               rst_pend, rst_pending, rst_exit;
  logic               grant_en, gnt_valid, gnt_idx, take, gnt_port;
  logic               sel_we;
  logic [LBUS_AW-1:0] sel_addr;
  logic [LBUS_DW-1:0] sel_wdata, lat_wdata;

  assign rst_pending = rst_pend | rst_req;
  assign grant_en    = (state == S_IDLE) && !rst_pending;
  assign sel_we      = gnt_idx ? we1    : we0;
  assign sel_addr    = gnt_idx ? addr1  : addr0;
  assign sel_wdata   = gnt_idx ? wdata1 : wdata0;

  lbus_rr_arb2 u_arb (
    .clk       (clk),
    .reset_i   (reset_i),
    .req       ({req1, req0}),
    .done      ({done1, done0}),
    .grant_en  (grant_en),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    rst_exit  = 1'b0;
    case (state)
      S_IDLE: begin
        if (rst_pending) begin
          state_nxt = S_RST;
          cnt_nxt   = CNT_W'(RST_CYC - 1);
        end else if (gnt_valid) begin
          take      = 1'b1;
          state_nxt = sel_we ? S_WADDR : S_RADDR;
        end
      end
      S_WADDR: state_nxt = S_WDATA;
      S_WDATA: begin
        state_nxt = S_GAP;
        cnt_nxt   = CNT_W'(GAP_CYC - 1);
      end
      S_RADDR: begin
        state_nxt = S_RWAIT;
        cnt_nxt   = CNT_W'(RD_LAT - 1);
      end
      S_RWAIT: begin
        if (cnt == '0) state_nxt = S_RCAP;
        else           cnt_nxt   = cnt - 1'b1;
      end
      S_RCAP: begin
        state_nxt = S_GAP;
        cnt_nxt   = CNT_W'(GAP_CYC - 1);
      end
      S_GAP: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      S_RST: begin
        if (cnt == '0) begin
          state_nxt = S_IDLE;
          rst_exit  = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so each pin matches its phase exactly.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rst_pend  <= 1'b0;
      gnt_port  <= 1'b0;
      busy      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      lbus_di_a <= '0;
      lbus_wrn  <= WRN_IDLE;
      lbus_rdn  <= RDN_IDLE;
      lbus_rstn <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rst_pend  <= rst_req | (rst_pend & ~rst_exit);
      busy      <= (state_nxt != S_IDLE);
      lbus_wrn  <= (state_nxt == S_WADDR || state_nxt == S_WDATA) ? ~WRN_IDLE : WRN_IDLE;
      lbus_rdn  <= (state_nxt == S_RADDR || state_nxt == S_RWAIT) ? ~RDN_IDLE : RDN_IDLE;
      lbus_rstn <= (state_nxt != S_RST);
      done0     <= 1'b0;
      done1     <= 1'b0;
      if (take) begin
        gnt_port  <= gnt_idx;
        lbus_di_a <= sel_addr;
      end
      if (state == S_WADDR) lbus_di_a <= lat_wdata;
      if (state == S_RCAP) begin
        if (gnt_port) rdata1 <= lbus_do;
        else          rdata0 <= lbus_do;
      end
      if (state == S_GAP && state_nxt == S_IDLE) begin
        if (gnt_port) done1 <= 1'b1;
        else          done0 <= 1'b1;
      end
    end
  end

  // NOTE: pure datapath register without reset; it is always loaded at grant before it is used.
  always_ff @(posedge clk) begin
    if (take) lat_wdata <= sel_wdata;
  end

endmodule

// File: tb/tb_lbus_arbiter_ctrl.sv
// Directed self-checking bench for lbus_arbiter_ctrl with RD_LAT=2,
// GAP_CYC=1, RST_CYC=8; bus-protocol monitors run for the whole test.
module tb_lbus_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, rst_req = 1'b0;
  logic [15:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0, lbus_do = '0;
  logic        done0, done1, busy, lbus_wrn, lbus_rdn, lbus_rstn;
  logic [15:0] rdata0, rdata1, lbus_di_a;

  int n_assert = 0;
  int n_fail   = 0;

  bit viol_wr_rd  = 1'b0;
  bit viol_rst    = 1'b0;
  bit viol_done   = 1'b0;

  always #5 clk = ~clk;

  lbus_arbiter_ctrl #(.RD_LAT(2), .GAP_CYC(1), .RST_CYC(8)) dut (
    .clk       (clk),
    .reset_i   (reset_i),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .done0     (done0),
    .rdata0    (rdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .done1     (done1),
    .rdata1    (rdata1),
    .rst_req   (rst_req),
    .busy      (busy),
    .lbus_di_a (lbus_di_a),
    .lbus_do   (lbus_do),
    .lbus_wrn  (lbus_wrn),
    .lbus_rdn  (lbus_rdn),
    .lbus_rstn (lbus_rstn)
  );

  // Protocol monitors: latch any violation, reported at the end of the run.
  always @(negedge clk) begin
    if (!lbus_wrn && !lbus_rdn)                  viol_wr_rd = 1'b1;
    if (!lbus_rstn && (!lbus_wrn || !lbus_rdn))  viol_rst   = 1'b1;
    if (done0 && done1)                          viol_done  = 1'b1;
  end

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    n_assert++;
    if ({lbus_wrn, lbus_rdn, lbus_rstn} !== 3'b111) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 111", {lbus_wrn, lbus_rdn, lbus_rstn});
    end
    n_assert++;
    if ({done0, done1, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_done_busy: got %b want 000", {done0, done1, busy});
    end
    n_assert++;
    if ({lbus_di_a, rdata0, rdata1} !== 48'h0) begin
      n_fail++; $display("FAIL reset_data: got di=%h r0=%h r1=%h want 0", lbus_di_a, rdata0, rdata1);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_single_write();
    logic [15:0] di_tr [1:3];
    logic        wrn_tr[1:3];
    int done_at = -1, done_cnt = 0;
    bit d1_seen = 1'b0;
    we0 = 1'b1; addr0 = 16'h0002; wdata0 = 16'h1234; req0 = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c <= 3) begin di_tr[c] = lbus_di_a; wrn_tr[c] = lbus_wrn; end
      if (done1) d1_seen = 1'b1;
      if (done0) begin
        done_cnt++;
        if (done_at < 0) begin done_at = c; req0 = 1'b0; end
      end
    end
    req0 = 1'b0;
    n_assert++;
    if (di_tr[1] !== 16'h0002 || wrn_tr[1] !== 1'b0) begin
      n_fail++; $display("FAIL wr_addr_phase: got di=%h wrn=%b want 0002/0", di_tr[1], wrn_tr[1]);
    end
    n_assert++;
    if (di_tr[2] !== 16'h1234 || wrn_tr[2] !== 1'b0) begin
      n_fail++; $display("FAIL wr_data_phase: got di=%h wrn=%b want 1234/0", di_tr[2], wrn_tr[2]);
    end
    n_assert++;
    if (wrn_tr[3] !== 1'b1) begin
      n_fail++; $display("FAIL wr_gap: got wrn=%b want 1", wrn_tr[3]);
    end
    n_assert++;
    if (done_at !== 4 || done_cnt !== 1) begin
      n_fail++; $display("FAIL wr_done0: got cycle %0d count %0d want 4/1", done_at, done_cnt);
    end
    n_assert++;
    if (d1_seen !== 1'b0) begin
      n_fail++; $display("FAIL wr_no_done1: got done1 pulse want none");
    end
  endtask

  task automatic test_single_read();
    int rdn_lo = 0, rdn_first = -1, done_at = -1;
    bit di_ok = 1'b1;
    logic [15:0] r1_at_done = '0;
    we1 = 1'b0; addr1 = 16'h0180; lbus_do = 16'hBEEF; req1 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (!lbus_rdn) begin
        rdn_lo++;
        if (rdn_first < 0) rdn_first = c;
        if (lbus_di_a !== 16'h0180) di_ok = 1'b0;
      end
      if (done1 && done_at < 0) begin done_at = c; r1_at_done = rdata1; req1 = 1'b0; end
    end
    req1 = 1'b0; lbus_do = 16'h0000;
    n_assert++;
    if (rdn_lo !== 3 || rdn_first !== 1) begin
      n_fail++; $display("FAIL rd_strobe: got %0d low cycles from %0d want 3 from 1", rdn_lo, rdn_first);
    end
    n_assert++;
    if (di_ok !== 1'b1) begin
      n_fail++; $display("FAIL rd_addr_hold: got di changing while rdn low want 0180 held");
    end
    n_assert++;
    if (done_at !== 6 || r1_at_done !== 16'hBEEF) begin
      n_fail++; $display("FAIL rd_done1: got cycle %0d rdata1=%h want 6/BEEF", done_at, r1_at_done);
    end
    n_assert++;
    if (rdata0 !== 16'h0000) begin
      n_fail++; $display("FAIL rd_rdata0_kept: got %h want 0000", rdata0);
    end
  endtask

  task automatic test_contention();
    int   done_cyc [4] = '{default: -1};
    logic done_port[4] = '{default: 1'bx};
    int   nd = 0;
    bit   idle_ok = 1'b1;
    we0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'hAAAA;
    we1 = 1'b0; addr1 = 16'h0020; lbus_do = 16'h5A5A;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 1; c <= 40 && nd < 4; c++) begin
      @(negedge clk);
      if (done0 || done1) begin
        done_port[nd] = done1;
        done_cyc[nd]  = c;
        if (!(lbus_wrn && lbus_rdn)) idle_ok = 1'b0;
        nd++;
        if (nd == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_assert++;
    if ({done_port[0], done_port[1], done_port[2], done_port[3]} !== 4'b0101) begin
      n_fail++; $display("FAIL rr_order: got %b%b%b%b want 0101",
                         done_port[0], done_port[1], done_port[2], done_port[3]);
    end
    n_assert++;
    if (done_cyc[0] !== 4 || done_cyc[1] !== 10 || done_cyc[2] !== 14 || done_cyc[3] !== 20) begin
      n_fail++; $display("FAIL rr_timing: got %0d,%0d,%0d,%0d want 4,10,14,20",
                         done_cyc[0], done_cyc[1], done_cyc[2], done_cyc[3]);
    end
    n_assert++;
    if (idle_ok !== 1'b1 || rdata1 !== 16'h5A5A) begin
      n_fail++; $display("FAIL rr_idle_data: got idle_ok=%b rdata1=%h want 1/5A5A", idle_ok, rdata1);
    end
  endtask

  task automatic test_rst_req();
    int d0_at = -1, d1_at = -1, rst_lo = 0, rst_first = -1, rd_first = -1;
    we0 = 1'b1; addr0 = 16'h0030; wdata0 = 16'h4321;
    we1 = 1'b0; addr1 = 16'h0040; lbus_do = 16'h2468;
    req0 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (!lbus_rstn) begin
        rst_lo++;
        if (rst_first < 0) rst_first = c;
      end
      if (!lbus_rdn && rd_first < 0) rd_first = c;
      if (done0 && d0_at < 0) begin d0_at = c; req0 = 1'b0; end
      if (done1 && d1_at < 0) begin d1_at = c; req1 = 1'b0; end
      if (c == 1) rst_req = 1'b1;
      if (c == 2) begin rst_req = 1'b0; req1 = 1'b1; end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_assert++;
    if (d0_at !== 4) begin
      n_fail++; $display("FAIL rst_write_done: got done0 at %0d want 4", d0_at);
    end
    n_assert++;
    if (rst_first !== 5 || rst_lo !== 8) begin
      n_fail++; $display("FAIL rst_pulse: got start %0d len %0d want 5/8", rst_first, rst_lo);
    end
    n_assert++;
    if (rd_first !== 14 || d1_at !== 19 || rdata1 !== 16'h2468) begin
      n_fail++; $display("FAIL rst_then_read: got rdn %0d done1 %0d rdata1 %h want 14/19/2468",
                         rd_first, d1_at, rdata1);
    end
  endtask

  task automatic test_reset_mid();
    int   nd = 0;
    int   dcyc [2] = '{default: -1};
    logic dport[2] = '{default: 1'bx};
    // Abort a port-0 read so the arbiter's last winner is 0 before reset.
    we0 = 1'b0; addr0 = 16'h0050; lbus_do = 16'h0BAD; req0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_assert++;
    if (lbus_rdn !== 1'b0) begin
      n_fail++; $display("FAIL mid_rwait: got rdn=%b want 0", lbus_rdn);
    end
    reset_i = 1'b1; req0 = 1'b0;
    @(negedge clk);
    n_assert++;
    if ({lbus_rdn, busy, done0, done1, lbus_rstn} !== 5'b10001 || rdata0 !== 16'h0000) begin
      n_fail++; $display("FAIL mid_reset_outputs: got rdn,busy,d0,d1,rstn=%b rdata0=%h want 10001/0000",
                         {lbus_rdn, busy, done0, done1, lbus_rstn}, rdata0);
    end
    reset_i = 1'b0;
    we0 = 1'b1; addr0 = 16'h0070; wdata0 = 16'h7777;
    we1 = 1'b0; addr1 = 16'h0060; lbus_do = 16'h1357;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 1; c <= 20 && nd < 2; c++) begin
      @(negedge clk);
      if (done0 || done1) begin
        dport[nd] = done1; dcyc[nd] = c;
        if (done0) req0 = 1'b0;
        if (done1) req1 = 1'b0;
        nd++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_assert++;
    if (dport[0] !== 1'b0 || dcyc[0] !== 4) begin
      n_fail++; $display("FAIL mid_rr_reset: got first port %b at %0d want 0 at 4", dport[0], dcyc[0]);
    end
    n_assert++;
    if (dport[1] !== 1'b1 || dcyc[1] !== 10 || rdata1 !== 16'h1357) begin
      n_fail++; $display("FAIL mid_read_after: got port %b at %0d rdata1=%h want 1 at 10/1357",
                         dport[1], dcyc[1], rdata1);
    end
  endtask

  task automatic test_properties();
    n_assert++;
    if (viol_wr_rd !== 1'b0) begin
      n_fail++; $display("FAIL prop_wrn_rdn: got both strobes low want never");
    end
    n_assert++;
    if (viol_rst !== 1'b0) begin
      n_fail++; $display("FAIL prop_rstn_strobe: got rstn low with strobe low want never");
    end
    n_assert++;
    if (viol_done !== 1'b0) begin
      n_fail++; $display("FAIL prop_done_onehot: got done0 and done1 together want never");
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_rst_req();
    test_reset_mid();
    repeat (2) @(negedge clk);
    test_properties();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
